// File: rtl/sample_seq_ctrl_pkg.sv
// rtl/sample_seq_ctrl_pkg.sv - shared opcode and sequencer state types
package sample_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_LOAD = 2'd1,
        OP_MAC  = 2'd2,
        OP_CLR  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_DONE,
        S_ERROR
    } state_t;

    function automatic op_t state_op(state_t s);
        case (s)
            S_LOAD:  return OP_LOAD;
            S_MAC:   return OP_MAC;
            S_ERROR: return OP_CLR;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sample_seq_ctrl_flex_counter.sv
// rtl/sample_seq_ctrl_flex_counter.sv - flex_counter: wrapping counter with rollover flag
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_next;

    // After reaching rollover_val the next increment wraps to 1, not 0
    always_comb begin
        count_next = count_out + NUM_CNT_BITS'(1);
        if (count_out == rollover_val) begin
            count_next = NUM_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else if (clear) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else if (count_enable) begin
            count_out     <= count_next;
            rollover_flag <= (count_next == rollover_val);
        end
    end

endmodule

// File: rtl/sample_seq_ctrl.sv
// rtl/sample_seq_ctrl.sv - per-sample LOAD/MAC sequencer with overrun and window counting
module sample_seq_ctrl
    import sample_seq_ctrl_pkg::*;
#(
    parameter int NUM_TAPS = 4,
    parameter int WINDOW   = 1000,
    parameter int CW       = 10
) (
    input  logic                        clk,
    input  logic                        n_reset,
    input  logic                        data_ready,
    input  logic                        overflow,
    input  logic                        clear_window,
    output logic [1:0]                  op,
    output logic [$clog2(NUM_TAPS)-1:0] tap_sel,
    output logic                        load_sample,
    output logic                        result_valid,
    output logic                        err,
    output logic                        busy,
    output logic                        window_done,
    output logic [CW-1:0]               sample_count
);

    localparam int TW = $clog2(NUM_TAPS);
    localparam logic [TW-1:0] LAST_TAP = TW'(NUM_TAPS - 1);

    state_t        state, state_nxt;
    logic [TW-1:0] tap, tap_nxt;
    logic          pending, pending_nxt;
    logic          err_nxt;
    op_t           op_r;
    logic          rollover_flag, rollover_flag_d;

    always_comb begin
        state_nxt   = state;
        tap_nxt     = tap;
        pending_nxt = pending;
        err_nxt     = err;
        case (state)
            S_LOAD: begin
                state_nxt = S_MAC;
                tap_nxt   = '0;
            end
            S_MAC: begin
                if (overflow) begin
                    state_nxt = S_ERROR;
                    err_nxt   = 1'b1;
                end else if (tap == LAST_TAP) begin
                    state_nxt = S_DONE;
                end else begin
                    tap_nxt = tap + TW'(1);
                end
            end
            default: begin
                // IDLE, DONE, ERROR: a fresh data_ready arriving while pending
                // is consumed stays queued as the next pending sample
                if (data_ready || pending) begin
                    state_nxt   = S_LOAD;
                    pending_nxt = pending & data_ready;
                    err_nxt     = 1'b0;
                end else if (state == S_DONE) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
        if ((state == S_LOAD || state == S_MAC) && data_ready) begin
            if (pending) begin
                err_nxt = 1'b1;
            end else begin
                pending_nxt = 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state        <= S_IDLE;
            tap          <= '0;
            pending      <= 1'b0;
            err          <= 1'b0;
            op_r         <= OP_NOP;
            tap_sel      <= '0;
            load_sample  <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            tap          <= tap_nxt;
            pending      <= pending_nxt;
            err          <= err_nxt;
            op_r         <= state_op(state_nxt);
            tap_sel      <= (state_nxt == S_MAC) ? tap_nxt : '0;
            load_sample  <= (state_nxt == S_LOAD);
            result_valid <= (state_nxt == S_DONE);
            busy         <= (state_nxt == S_LOAD) || (state_nxt == S_MAC) || (state_nxt == S_DONE);
        end
    end

    assign op = op_r;

    flex_counter #(
        .NUM_CNT_BITS(CW)
    ) u_window_cnt (
        .clk          (clk),
        .n_rst        (n_reset),
        .clear        (clear_window),
        .count_enable (state == S_DONE),
        .rollover_val (CW'(WINDOW)),
        .count_out    (sample_count),
        .rollover_flag(rollover_flag)
    );

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rollover_flag_d <= 1'b0;
        end else begin
            rollover_flag_d <= rollover_flag;
        end
    end

    assign window_done = rollover_flag & ~rollover_flag_d;

endmodule

// File: tb/tb_sample_seq_ctrl.sv
// tb/tb_sample_seq_ctrl.sv - directed self-checking bench for sample_seq_ctrl
module tb_sample_seq_ctrl;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       data_ready;
    logic       overflow;
    logic       clear_window;
    logic [1:0] op;
    logic [1:0] tap_sel;
    logic       load_sample;
    logic       result_valid;
    logic       err;
    logic       busy;
    logic       window_done;
    logic [9:0] sample_count;

    int checks   = 0;
    int failures = 0;
    int wd_pulses = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (window_done === 1'b1) wd_pulses++;

    sample_seq_ctrl #(.NUM_TAPS(4), .WINDOW(5), .CW(10)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .data_ready  (data_ready),
        .overflow    (overflow),
        .clear_window(clear_window),
        .op          (op),
        .tap_sel     (tap_sel),
        .load_sample (load_sample),
        .result_valid(result_valid),
        .err         (err),
        .busy        (busy),
        .window_done (window_done),
        .sample_count(sample_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        n_reset = 1'b0; data_ready = 1'b0; overflow = 1'b0; clear_window = 1'b0;
        tick;
        n_reset = 1'b1;
    endtask

    task automatic run_sample;
        data_ready = 1'b1;
        tick;
        data_ready = 1'b0;
        repeat (6) tick;
    endtask

    task automatic test_reset;
        n_reset = 1'b0; data_ready = 1'b0; overflow = 1'b0; clear_window = 1'b0;
        tick;
        checks++;
        if ({op, tap_sel, load_sample, result_valid, err, busy, window_done} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", {op, tap_sel, load_sample, result_valid, err, busy, window_done}, 9'b0);
        end
        checks++;
        if (sample_count !== 10'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d want=0", sample_count);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_single;
        logic [6:0] exp_v [7];
        exp_v[0] = 7'b0100101;
        exp_v[1] = 7'b1000001;
        exp_v[2] = 7'b1001001;
        exp_v[3] = 7'b1010001;
        exp_v[4] = 7'b1011001;
        exp_v[5] = 7'b0000011;
        exp_v[6] = 7'b0000000;
        data_ready = 1'b1;
        tick;
        data_ready = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if ({op, tap_sel, load_sample, result_valid, busy} !== exp_v[c-1]) begin
                failures++;
                $display("FAIL single_cycle%0d got=%b want=%b", c, {op, tap_sel, load_sample, result_valid, busy}, exp_v[c-1]);
            end
            if (c < 7) tick;
        end
        checks++;
        if (sample_count !== 10'd1 || err !== 1'b0) begin
            failures++;
            $display("FAIL single_done count=%0d err=%b want count=1 err=0", sample_count, err);
        end
    endtask

    task automatic test_overflow;
        data_ready = 1'b1;
        tick;
        data_ready = 1'b0;
        repeat (3) tick;
        checks++;
        if (tap_sel !== 2'd2 || op !== 2'd2) begin
            failures++;
            $display("FAIL ovf_tap2 tap=%0d op=%0d want tap=2 op=2", tap_sel, op);
        end
        overflow = 1'b1;
        tick;
        overflow = 1'b0;
        checks++;
        if (op !== 2'd3 || err !== 1'b1 || busy !== 1'b0 || sample_count !== 10'd1) begin
            failures++;
            $display("FAIL ovf_error op=%0d err=%b busy=%b count=%0d want op=3 err=1 busy=0 count=1", op, err, busy, sample_count);
        end
        tick;
        checks++;
        if (op !== 2'd3 || err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_hold op=%0d err=%b want op=3 err=1", op, err);
        end
        data_ready = 1'b1;
        tick;
        data_ready = 1'b0;
        checks++;
        if (load_sample !== 1'b1 || err !== 1'b0 || op !== 2'd1) begin
            failures++;
            $display("FAIL ovf_reload load=%b err=%b op=%0d want load=1 err=0 op=1", load_sample, err, op);
        end
        repeat (6) tick;
        checks++;
        if (sample_count !== 10'd2) begin
            failures++;
            $display("FAIL ovf_count got=%0d want=2", sample_count);
        end
    endtask

    task automatic test_window;
        int w0;
        do_reset;
        w0 = wd_pulses;
        repeat (4) run_sample;
        checks++;
        if (sample_count !== 10'd4 || wd_pulses !== w0) begin
            failures++;
            $display("FAIL window_pre count=%0d pulses=%0d want count=4 pulses=0", sample_count, wd_pulses - w0);
        end
        run_sample;
        checks++;
        if (window_done !== 1'b1 || sample_count !== 10'd5) begin
            failures++;
            $display("FAIL window_hit wd=%b count=%0d want wd=1 count=5", window_done, sample_count);
        end
        run_sample;
        checks++;
        if (sample_count !== 10'd1 || window_done !== 1'b0 || wd_pulses - w0 !== 1) begin
            failures++;
            $display("FAIL window_wrap count=%0d wd=%b pulses=%0d want count=1 wd=0 pulses=1", sample_count, window_done, wd_pulses - w0);
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        data_ready = 1'b1;
        tick;
        data_ready = 1'b0;
        tick;
        tick;
        data_ready = 1'b1;
        tick;
        tick;
        data_ready = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_overrun err=%b busy=%b want err=1 busy=1", err, busy);
        end
        tick;
        checks++;
        if (result_valid !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done rv=%b err=%b want rv=1 err=1", result_valid, err);
        end
        tick;
        checks++;
        if (load_sample !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_reload load=%b err=%b busy=%b want load=1 err=0 busy=1", load_sample, err, busy);
        end
        repeat (6) tick;
        checks++;
        if (sample_count !== 10'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end count=%0d busy=%b want count=2 busy=0", sample_count, busy);
        end
    endtask

    task automatic test_clear_window;
        int w0;
        do_reset;
        repeat (4) run_sample;
        w0 = wd_pulses;
        data_ready = 1'b1;
        tick;
        data_ready = 1'b0;
        repeat (5) tick;
        checks++;
        if (result_valid !== 1'b1 || sample_count !== 10'd4) begin
            failures++;
            $display("FAIL clr_done rv=%b count=%0d want rv=1 count=4", result_valid, sample_count);
        end
        clear_window = 1'b1;
        tick;
        clear_window = 1'b0;
        checks++;
        if (sample_count !== 10'd0 || window_done !== 1'b0) begin
            failures++;
            $display("FAIL clr_result count=%0d wd=%b want count=0 wd=0", sample_count, window_done);
        end
        tick;
        checks++;
        if (wd_pulses !== w0) begin
            failures++;
            $display("FAIL clr_pulses got=%0d want=0", wd_pulses - w0);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        run_sample;
        data_ready = 1'b1;
        tick;
        data_ready = 1'b0;
        tick;
        data_ready = 1'b1;
        tick;
        data_ready = 1'b0;
        checks++;
        if (tap_sel !== 2'd1 || op !== 2'd2) begin
            failures++;
            $display("FAIL mid_tap1 tap=%0d op=%0d want tap=1 op=2", tap_sel, op);
        end
        n_reset = 1'b0;
        tick;
        n_reset = 1'b1;
        checks++;
        if ({op, tap_sel, load_sample, result_valid, err, busy, window_done} !== 9'b0 || sample_count !== 10'd0) begin
            failures++;
            $display("FAIL mid_reset outs=%b count=%0d want outs=0 count=0", {op, tap_sel, load_sample, result_valid, err, busy, window_done}, sample_count);
        end
        repeat (3) tick;
        checks++;
        if (busy !== 1'b0 || load_sample !== 1'b0) begin
            failures++;
            $display("FAIL mid_pending busy=%b load=%b want busy=0 load=0", busy, load_sample);
        end
        run_sample;
        checks++;
        if (sample_count !== 10'd1 || err !== 1'b0) begin
            failures++;
            $display("FAIL mid_rerun count=%0d err=%b want count=1 err=0", sample_count, err);
        end
    endtask

    initial begin
        n_reset = 1'b0; data_ready = 1'b0; overflow = 1'b0; clear_window = 1'b0;
        #1;
        test_reset;
        test_single;
        test_overflow;
        test_window;
        test_back_to_back;
        test_clear_window;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
